// File: rtl/biquad8_pkg.sv
// Shared definitions for the biquad8 coefficient path: replay order,
// address-to-slot mapping and sequencer state encoding.
package biquad8_pkg;

  localparam int NSTEP = 23;

  // Replay order; a shadow slot index is the step at which that word is replayed.
  localparam logic [7:0] SEQ_ADR [NSTEP] = '{
    8'd24, 8'd23, 8'd22, 8'd21, 8'd20, 8'd19, 8'd18, 8'd17, 8'd16,
    8'd7,  8'd6,  8'd5,  8'd4,  8'd3,  8'd2,  8'd1,  8'd0,
    8'd35, 8'd34, 8'd33, 8'd32,
    8'd49, 8'd48
  };

  typedef struct packed {
    logic       vld;
    logic [4:0] slot;
  } slot_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_HOLD, ST_GAP, ST_UPD, ST_DONE
  } state_e;

  function automatic slot_t adr2slot(input logic [7:0] adr);
    slot_t r;
    r = '0;
    if (adr >= 8'd16 && adr <= 8'd24) begin
      r.vld  = 1'b1;
      r.slot = 5'(24 - int'(adr));
    end else if (adr <= 8'd7) begin
      r.vld  = 1'b1;
      r.slot = 5'(16 - int'(adr));
    end else if (adr >= 8'd32 && adr <= 8'd35) begin
      r.vld  = 1'b1;
      r.slot = 5'(52 - int'(adr));
    end else if (adr == 8'd48 || adr == 8'd49) begin
      r.vld  = 1'b1;
      r.slot = 5'(70 - int'(adr));
    end
    return r;
  endfunction

endpackage

// File: rtl/biquad8_coeff_shadow.sv
// Per-channel coefficient shadow RAM: one synchronous write port,
// one read port with a 1-clock registered output. Contents are not reset.
module biquad8_coeff_shadow
  import biquad8_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int COEFF_W = 18,
  parameter int CHW     = 2
) (
  input  logic               clk,
  input  logic               wr_i,
  input  logic [CHW-1:0]     wr_ch_i,
  input  logic [4:0]         wr_slot_i,
  input  logic [COEFF_W-1:0] wr_dat_i,
  input  logic [CHW-1:0]     rd_ch_i,
  input  logic [4:0]         rd_slot_i,
  output logic [COEFF_W-1:0] rd_dat_o
);

  localparam int AW = $clog2(NCH * NSTEP);

  logic [COEFF_W-1:0] mem_q [NCH*NSTEP];
  logic [COEFF_W-1:0] rd_q;
  logic [AW-1:0]      wa, ra;

  assign wa = AW'(int'(wr_ch_i) * NSTEP + int'(wr_slot_i));
  assign ra = AW'(int'(rd_ch_i) * NSTEP + int'(rd_slot_i));

  always_ff @(posedge clk) begin
    if (wr_i) mem_q[wa] <= wr_dat_i;
    rd_q <= mem_q[ra];
  end

  assign rd_dat_o = rd_q;

endmodule

// File: rtl/biquad8_coeff_sequencer.sv
// Coefficient sequencer: shadows host writes, replays them last-address-first
// into the masked biquad8 chains with a write hold, then strobes the update.
module biquad8_coeff_sequencer
  import biquad8_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int COEFF_W = 18,
  parameter int HOLD    = 16,
  parameter int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_wr_i,
  input  logic [CHW-1:0]     cfg_ch_i,
  input  logic [7:0]         cfg_adr_i,
  input  logic [COEFF_W-1:0] cfg_dat_i,
  output logic               cfg_err_o,
  input  logic               commit_i,
  input  logic [NCH-1:0]     commit_mask_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [7:0]         coeff_adr_o,
  output logic [COEFF_W-1:0] coeff_dat_o,
  output logic [NCH-1:0]     coeff_wr_o,
  output logic [NCH-1:0]     coeff_update_o
);

  localparam int HCW = (HOLD > 2) ? $clog2(HOLD) : 1;

  state_e             state_q, state_d;
  logic [4:0]         step_q, step_d;
  logic [HCW-1:0]     hcnt_q, hcnt_d;
  logic [NCH-1:0]     mask_q, mask_d, cmask_q;
  logic [7:0]         adr_q, adr_d;
  logic [COEFF_W-1:0] dat_q, rd_dat;
  logic               err_q, cmt_q;
  logic [CHW-1:0]     src_ch;
  slot_t              wslot;
  logic               wr_ok;

  assign wslot = adr2slot(cfg_adr_i);
  assign wr_ok = wslot.vld && (int'(cfg_ch_i) < NCH) && (state_q == ST_IDLE);

  // The data bus is shared, so a replay sources the lowest channel in the mask.
  always_comb begin
    src_ch = '0;
    for (int c = NCH - 1; c >= 0; c--)
      if (mask_d[c]) src_ch = CHW'(c);
  end

  biquad8_coeff_shadow #(.NCH(NCH), .COEFF_W(COEFF_W), .CHW(CHW)) u_shadow (
    .clk       (clk),
    .wr_i      (cfg_wr_i && wr_ok),
    .wr_ch_i   (cfg_ch_i),
    .wr_slot_i (wslot.slot),
    .wr_dat_i  (cfg_dat_i),
    .rd_ch_i   (src_ch),
    .rd_slot_i (step_d),
    .rd_dat_o  (rd_dat)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    hcnt_d  = hcnt_q;
    mask_d  = mask_q;
    adr_d   = adr_q;
    case (state_q)
      ST_IDLE: if (cmt_q) begin
        mask_d  = cmask_q;
        step_d  = '0;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        hcnt_d  = '0;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (hcnt_q == HCW'(HOLD - 1)) state_d = ST_GAP;
        else                          hcnt_d  = hcnt_q + 1'b1;
      end
      ST_GAP: begin
        if (step_q == 5'(NSTEP - 1)) state_d = ST_UPD;
        else begin
          step_d  = step_q + 5'd1;
          state_d = ST_LOAD;
        end
      end
      ST_UPD:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_LOAD) adr_d = SEQ_ADR[step_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      hcnt_q  <= '0;
      mask_q  <= '0;
      cmask_q <= '0;
      cmt_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      hcnt_q  <= hcnt_d;
      mask_q  <= mask_d;
      // Commit is registered once; only a single pulse taken in IDLE can start a replay.
      cmt_q   <= commit_i && (|commit_mask_i) && (state_q == ST_IDLE) && !cmt_q;
      cmask_q <= commit_mask_i;
      adr_q   <= adr_d;
      if (state_q == ST_LOAD) dat_q <= rd_dat;
      err_q   <= cfg_wr_i && !wr_ok;
    end
  end

  // During LOAD the fresh shadow word goes straight out, so data moves only with LOAD.
  assign coeff_dat_o    = (state_q == ST_LOAD) ? rd_dat : dat_q;
  assign coeff_adr_o    = adr_q;
  assign coeff_wr_o     = (state_q == ST_HOLD) ? mask_q : '0;
  assign coeff_update_o = (state_q == ST_UPD)  ? mask_q : '0;
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = (state_q == ST_DONE);
  assign cfg_err_o      = err_q;

endmodule

// File: tb/tb_biquad8_coeff_sequencer.sv
// Randomized bench for biquad8_coeff_sequencer against a queue/array reference
// model of the replay order, timing and masking; plus a HOLD=2, NCH=1 instance.
module tb_biquad8_coeff_sequencer;
  localparam int NCH = 4, CW = 18, HOLD = 16;
  localparam int REPLAY = 23 * (HOLD + 2) + 2;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           cfg_wr_i, cfg_err_o, commit_i, busy_o, done_o;
  logic [1:0]     cfg_ch_i;
  logic [7:0]     cfg_adr_i, coeff_adr_o;
  logic [CW-1:0]  cfg_dat_i, coeff_dat_o;
  logic [NCH-1:0] commit_mask_i, coeff_wr_o, coeff_update_o;

  logic          s_cfg_wr_i, s_cfg_err_o, s_commit_i, s_busy_o, s_done_o;
  logic [0:0]    s_cfg_ch_i, s_commit_mask_i, s_coeff_wr_o, s_coeff_update_o;
  logic [7:0]    s_cfg_adr_i, s_coeff_adr_o;
  logic [CW-1:0] s_cfg_dat_i, s_coeff_dat_o;

  biquad8_coeff_sequencer #(.NCH(NCH), .COEFF_W(CW), .HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr_i(cfg_wr_i), .cfg_ch_i(cfg_ch_i),
    .cfg_adr_i(cfg_adr_i), .cfg_dat_i(cfg_dat_i), .cfg_err_o(cfg_err_o),
    .commit_i(commit_i), .commit_mask_i(commit_mask_i), .busy_o(busy_o),
    .done_o(done_o), .coeff_adr_o(coeff_adr_o), .coeff_dat_o(coeff_dat_o),
    .coeff_wr_o(coeff_wr_o), .coeff_update_o(coeff_update_o));

  biquad8_coeff_sequencer #(.NCH(1), .COEFF_W(CW), .HOLD(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .cfg_wr_i(s_cfg_wr_i), .cfg_ch_i(s_cfg_ch_i),
    .cfg_adr_i(s_cfg_adr_i), .cfg_dat_i(s_cfg_dat_i), .cfg_err_o(s_cfg_err_o),
    .commit_i(s_commit_i), .commit_mask_i(s_commit_mask_i), .busy_o(s_busy_o),
    .done_o(s_done_o), .coeff_adr_o(s_coeff_adr_o), .coeff_dat_o(s_coeff_dat_o),
    .coeff_wr_o(s_coeff_wr_o), .coeff_update_o(s_coeff_update_o));

  int n_chk = 0, n_err = 0;
  int seq_q[$];
  logic [CW-1:0] ref_mem [int];
  logic [CW-1:0] s_ref [int];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input int ch, input int adr, input logic [CW-1:0] dat, output logic err);
    cfg_wr_i = 1'b1; cfg_ch_i = 2'(ch); cfg_adr_i = 8'(adr); cfg_dat_i = dat;
    @(negedge clk);
    cfg_wr_i = 1'b0;
    err = cfg_err_o;
  endtask

  task automatic replay(input logic [NCH-1:0] mask, input int inj_commit, input int inj_wr, input bit same_wr);
    int cyc = 0, done_cyc = -1, upd_cyc = -1, upd_cnt = 0, busy_cyc = -1, wr_cyc = -1;
    int bad_win = 0, unstable = 0, errs = 0, win = 0, src = 0;
    logic [NCH-1:0] prev_wr = '0, upd_seen = '0;
    logic [7:0] ha = '0;
    logic [CW-1:0] hd = '0;
    logic [7:0] b_adr[$];
    logic [CW-1:0] b_dat[$];
    logic [NCH-1:0] b_wr[$];
    for (int c = NCH - 1; c >= 0; c--) if (mask[c]) src = c;
    commit_i = 1'b1; commit_mask_i = mask;
    if (same_wr) begin
      cfg_wr_i = 1'b1; cfg_ch_i = 2'(src); cfg_adr_i = 8'd24; cfg_dat_i = CW'($urandom);
      ref_mem[src*256 + 24] = cfg_dat_i;
    end
    @(negedge clk);
    commit_i = 1'b0; cfg_wr_i = 1'b0;
    chk("busy_edge0", busy_o, 1'b0);
    while (done_cyc < 0 && cyc < REPLAY + 60) begin
      @(negedge clk); cyc++;
      if (busy_o && busy_cyc < 0) busy_cyc = cyc;
      if (coeff_wr_o != '0) begin
        if (wr_cyc < 0) wr_cyc = cyc;
        if (prev_wr == '0) begin
          b_adr.push_back(coeff_adr_o); b_dat.push_back(coeff_dat_o); b_wr.push_back(coeff_wr_o);
          win = 0; ha = coeff_adr_o; hd = coeff_dat_o;
        end
        win++;
        if (coeff_adr_o !== ha || coeff_dat_o !== hd || coeff_wr_o !== mask) unstable++;
      end else if (prev_wr != '0 && win != HOLD) bad_win++;
      prev_wr = coeff_wr_o;
      if (coeff_update_o != '0) begin upd_cnt++; upd_cyc = cyc; upd_seen = coeff_update_o; end
      if (cfg_err_o) errs++;
      if (done_o) done_cyc = cyc;
      commit_i = (cyc == inj_commit); commit_mask_i = 4'b0100;
      cfg_wr_i = (cyc == inj_wr); cfg_ch_i = 2'd0; cfg_adr_i = 8'd24; cfg_dat_i = ~ref_mem[24];
    end
    commit_i = 1'b0; cfg_wr_i = 1'b0;
    chk("busy_rise", busy_cyc, 1);
    chk("first_wr", wr_cyc, 2);
    chk("upd_cycle", upd_cyc, REPLAY - 1);
    chk("upd_count", upd_cnt, 1);
    chk("upd_mask", upd_seen, mask);
    chk("done_cycle", done_cyc, REPLAY);
    chk("wr_windows", bad_win, 0);
    chk("adr_dat_wr_stable", unstable, 0);
    chk("busy_wr_errs", errs, (inj_wr >= 0) ? 1 : 0);
    chk("beats", b_adr.size(), 23);
    for (int i = 0; i < 23 && i < b_adr.size(); i++) begin
      chk($sformatf("beat%0d_adr", i), b_adr[i], seq_q[i]);
      chk($sformatf("beat%0d_dat", i), b_dat[i], ref_mem[src*256 + seq_q[i]]);
      chk($sformatf("beat%0d_wr", i), b_wr[i], mask);
    end
    @(negedge clk);
    chk("busy_after_done", {busy_o, done_o}, 2'b00);
  endtask

  task automatic s_replay();
    int cyc = 0, done_cyc = -1, nbeat = 0, bad = 0, win = 0, seqbad = 0, upd = 0;
    logic prev = 1'b0;
    logic [7:0] ha = '0;
    logic [CW-1:0] hd = '0;
    s_commit_i = 1'b1; s_commit_mask_i = 1'b1;
    @(negedge clk);
    s_commit_i = 1'b0;
    while (done_cyc < 0 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (s_coeff_wr_o[0]) begin
        if (!prev) begin
          if (nbeat < 23 && (s_coeff_adr_o !== 8'(seq_q[nbeat]) || s_coeff_dat_o !== s_ref[seq_q[nbeat]])) seqbad++;
          nbeat++; win = 0; ha = s_coeff_adr_o; hd = s_coeff_dat_o;
        end
        win++;
        if (s_coeff_adr_o !== ha || s_coeff_dat_o !== hd) bad++;
      end else if (prev && win != 2) bad++;
      prev = s_coeff_wr_o[0];
      if (s_coeff_update_o[0]) upd++;
      if (s_done_o) done_cyc = cyc;
    end
    chk("s_done_cycle", done_cyc, 23 * 4 + 2);
    chk("s_beats", nbeat, 23);
    chk("s_windows_stable", bad, 0);
    chk("s_sequence", seqbad, 0);
    chk("s_update", upd, 1);
  endtask

  initial begin
    int wl[$];
    int errs, tmp, j, quiet;
    logic e;
    cfg_wr_i = 0; cfg_ch_i = 0; cfg_adr_i = 0; cfg_dat_i = 0; commit_i = 0; commit_mask_i = 0;
    s_cfg_wr_i = 0; s_cfg_ch_i = 0; s_cfg_adr_i = 0; s_cfg_dat_i = 0; s_commit_i = 0; s_commit_mask_i = 0;
    for (int a = 24; a >= 16; a--) seq_q.push_back(a);
    for (int a = 7; a >= 0; a--) seq_q.push_back(a);
    for (int a = 35; a >= 32; a--) seq_q.push_back(a);
    seq_q.push_back(49); seq_q.push_back(48);

    repeat (3) @(negedge clk);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", cfg_err_o, 1'b0);
    chk("rst_wr", coeff_wr_o, '0);
    chk("rst_upd", coeff_update_o, '0);
    chk("rst_adr", coeff_adr_o, '0);
    chk("rst_dat", coeff_dat_o, '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int c = 0; c < NCH; c++) foreach (seq_q[i]) wl.push_back(c * 256 + seq_q[i]);
    for (int i = wl.size() - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0)); tmp = wl[i]; wl[i] = wl[j]; wl[j] = tmp;
    end
    errs = 0;
    foreach (wl[i]) begin
      ref_mem[wl[i]] = CW'($urandom);
      cfg_write(wl[i] / 256, wl[i] % 256, ref_mem[wl[i]], e);
      if (e) errs++;
    end
    chk("valid_writes_no_err", errs, 0);
    foreach (seq_q[i]) begin
      s_ref[seq_q[i]] = CW'($urandom);
      s_cfg_wr_i = 1'b1; s_cfg_ch_i = 1'b0; s_cfg_adr_i = 8'(seq_q[i]); s_cfg_dat_i = s_ref[seq_q[i]];
      @(negedge clk);
    end
    s_cfg_wr_i = 1'b0;

    replay(4'b0001, -1, -1, 1'b0);
    replay(4'b1010, -1, -1, 1'b1);

    cfg_write(0, 8, CW'($urandom), e);
    chk("err_adr8", e, 1'b1);
    cfg_write(2, 50, CW'($urandom), e);
    chk("err_adr50", e, 1'b1);
    @(negedge clk);
    chk("err_single_pulse", cfg_err_o, 1'b0);

    replay(4'(1 + $urandom_range(14, 0)), 1 + 5 * (HOLD + 2) + 3, 100, 1'b0);

    commit_i = 1'b1; commit_mask_i = '0;
    @(negedge clk);
    commit_i = 1'b0;
    quiet = 0;
    repeat (4) begin @(negedge clk); if (busy_o) quiet++; end
    chk("mask0_ignored", quiet, 0);

    replay(4'b0101, -1, -1, 1'b0);

    commit_i = 1'b1; commit_mask_i = 4'hF;
    @(negedge clk);
    commit_i = 1'b0;
    repeat (1 + 10 * (HOLD + 2) + 5) @(negedge clk);
    chk("pre_rst_wr", coeff_wr_o, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {busy_o, done_o, coeff_wr_o, coeff_update_o}, '0);
    quiet = 0;
    repeat (5) begin @(negedge clk); if (coeff_update_o != '0 || busy_o) quiet++; end
    chk("rst_quiet", quiet, 0);
    rst_n = 1'b1;
    @(negedge clk);
    replay(4'hF, -1, -1, 1'b0);

    s_replay();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
